// File: rtl/vga_write_arbiter.sv
// Two-requester arbiter for a single VGA frame-buffer write port.
// Round-robin on contention, bounded hold time, one dead cycle on every grant change.
module vga_write_arbiter #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned C_W      = 3,
  parameter int unsigned MAX_HOLD = 255
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req0,
  input  logic           plot0,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [C_W-1:0] c0,
  input  logic           req1,
  input  logic           plot1,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  input  logic [C_W-1:0] c1,
  output logic           gnt0,
  output logic           gnt1,
  output logic [X_W-1:0] X,
  output logic [Y_W-1:0] Y,
  output logic [C_W-1:0] color,
  output logic           draw_enable,
  output logic           busy
);

  localparam int unsigned HOLD_W    = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2,
    S_SWITCH = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                last_grant, last_nxt;

  // State, hold counter and round-robin pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      last_grant <= last_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last_grant;
    unique case (state)
      S_IDLE: begin
        if (req0 && req1)  state_nxt = last_grant ? S_GRANT0 : S_GRANT1;
        else if (req0)     state_nxt = S_GRANT0;
        else if (req1)     state_nxt = S_GRANT1;
      end
      S_GRANT0: begin
        if (req1 && hold_cnt != HOLD_SAT) hold_nxt = hold_cnt + HOLD_W'(1);
        if (!req0 || (req1 && hold_cnt == HOLD_LAST)) state_nxt = S_SWITCH;
      end
      S_GRANT1: begin
        if (req0 && hold_cnt != HOLD_SAT) hold_nxt = hold_cnt + HOLD_W'(1);
        if (!req1 || (req0 && hold_cnt == HOLD_LAST)) state_nxt = S_SWITCH;
      end
      S_SWITCH: begin
        // last_grant still names the requester that just released
        if (last_grant) begin
          if (req0)      state_nxt = S_GRANT0;
          else if (req1) state_nxt = S_GRANT1;
          else           state_nxt = S_IDLE;
        end else begin
          if (req1)      state_nxt = S_GRANT1;
          else if (req0) state_nxt = S_GRANT0;
          else           state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_GRANT0 && state != S_GRANT0) begin
      hold_nxt = '0;
      last_nxt = 1'b0;
    end else if (state_nxt == S_GRANT1 && state != S_GRANT1) begin
      hold_nxt = '0;
      last_nxt = 1'b1;
    end
  end

  // Grant/busy flops mirror the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      busy <= 1'b0;
    end else begin
      gnt0 <= (state_nxt == S_GRANT0);
      gnt1 <= (state_nxt == S_GRANT1);
      busy <= (state_nxt != S_IDLE);
    end
  end

  // Pixel pipeline: one-cycle latency from granted plot to frame-buffer write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      draw_enable <= 1'b0;
      X           <= '0;
      Y           <= '0;
      color       <= '0;
    end else begin
      draw_enable <= (gnt0 && plot0) || (gnt1 && plot1);
      if (gnt0 && plot0) begin
        X     <= x0;
        Y     <= y0;
        color <= c0;
      end else if (gnt1 && plot1) begin
        X     <= x1;
        Y     <= y1;
        color <= c1;
      end
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Random and directed bench for vga_write_arbiter against a behavioural arbitration model.
module tb_vga_write_arbiter;
  localparam int unsigned X_W  = 8;
  localparam int unsigned Y_W  = 7;
  localparam int unsigned C_W  = 3;
  localparam int unsigned MAXH = 4;

  logic clock = 1'b0;
  logic reset;
  logic req0, plot0, req1, plot1;
  logic [X_W-1:0] x0, x1;
  logic [Y_W-1:0] y0, y1;
  logic [C_W-1:0] c0, c1;
  logic gnt0, gnt1, draw_enable, busy;
  logic [X_W-1:0] X;
  logic [Y_W-1:0] Y;
  logic [C_W-1:0] color;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who holds the port (-1 none), pending dead cycle, last owner, contested run length
  int m_holder, m_gap, m_last, m_run;
  logic m_de;
  logic [X_W-1:0] m_x;
  logic [Y_W-1:0] m_y;
  logic [C_W-1:0] m_c;

  vga_write_arbiter #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_HOLD(MAXH)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .plot0(plot0), .x0(x0), .y0(y0), .c0(c0),
    .req1(req1), .plot1(plot1), .x1(x1), .y1(y1), .c1(c1),
    .gnt0(gnt0), .gnt1(gnt1), .X(X), .Y(Y), .color(color),
    .draw_enable(draw_enable), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_holder = -1; m_gap = 0; m_last = 1; m_run = 0;
    m_de = 1'b0; m_x = '0; m_y = '0; m_c = '0;
  endtask

  task automatic model_edge();
    int nh;
    logic [1:0] rq;
    rq = {req1, req0};
    if (m_holder == 0 && plot0) begin
      m_de = 1'b1; m_x = x0; m_y = y0; m_c = c0;
    end else if (m_holder == 1 && plot1) begin
      m_de = 1'b1; m_x = x1; m_y = y1; m_c = c1;
    end else begin
      m_de = 1'b0;
    end
    nh = -1;
    if (m_gap != 0) begin
      m_gap = 0;
      if (rq[1-m_last])    nh = 1 - m_last;
      else if (rq[m_last]) nh = m_last;
    end else if (m_holder < 0) begin
      if (rq == 2'b11)   nh = 1 - m_last;
      else if (rq[0])    nh = 0;
      else if (rq[1])    nh = 1;
    end else begin
      if (!rq[m_holder] || (rq[1-m_holder] && m_run == int'(MAXH) - 1)) begin
        m_holder = -1;
        m_gap = 1;
      end else if (rq[1-m_holder] && m_run < 255) begin
        m_run++;
      end
    end
    if (nh >= 0) begin
      m_holder = nh; m_last = nh; m_run = 0;
    end
  endtask

  task automatic compare_all();
    chk("gnt0", 32'(gnt0), 32'(m_holder == 0));
    chk("gnt1", 32'(gnt1), 32'(m_holder == 1));
    chk("busy", 32'(busy), 32'(m_holder >= 0 || m_gap != 0));
    chk("draw_enable", 32'(draw_enable), 32'(m_de));
    chk("X", 32'(X), 32'(m_x));
    chk("Y", 32'(Y), 32'(m_y));
    chk("color", 32'(color), 32'(m_c));
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  // Asynchronous reset pulse entirely between clock edges; called at a falling edge
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_draw", 32'(draw_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_X", 32'(X), 32'd0);
    chk("rst_Y", 32'(Y), 32'd0);
    chk("rst_color", 32'(color), 32'd0);
    model_reset();
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; plot0 = 0; x0 = '0; y0 = '0; c0 = '0;
    req1 = 0; plot1 = 0; x1 = '0; y1 = '0; c1 = '0;
    model_reset();
    #3;
    chk("init_gnt0", 32'(gnt0), 32'd0);
    chk("init_draw", 32'(draw_enable), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single requester plots one pixel
    req0 = 1; plot0 = 1; x0 = 8'd5; y0 = 7'd10; c0 = 3'b101;
    step();
    chk("r030_gnt0", 32'(gnt0), 32'd1);
    chk("r030_draw_first", 32'(draw_enable), 32'd0);
    step();
    chk("r030_draw", 32'(draw_enable), 32'd1);
    chk("r030_X", 32'(X), 32'd5);
    chk("r030_Y", 32'(Y), 32'd10);
    chk("r030_color", 32'(color), 32'd5);
    req0 = 0; plot0 = 0;
    step();
    step();
    chk("r030_idle_busy", 32'(busy), 32'd0);

    // Simultaneous request after reset goes to requester 0, then one dead cycle
    pulse_reset();
    req0 = 1; req1 = 1;
    step();
    chk("r031_gnt0", 32'(gnt0), 32'd1);
    req0 = 0;
    step();
    chk("r031_dead_gnt0", 32'(gnt0), 32'd0);
    chk("r031_dead_gnt1", 32'(gnt1), 32'd0);
    chk("r031_dead_busy", 32'(busy), 32'd1);
    step();
    chk("r031_gnt1", 32'(gnt1), 32'd1);
    plot1 = 1; x1 = 8'd77; y1 = 7'd33; c1 = 3'd6;
    step();
    chk("r034_draw_before", 32'(draw_enable), 32'd1);
    chk("r034_X_before", 32'(X), 32'd77);
    plot1 = 0; req1 = 0;
    pulse_reset();

    // Forced release after MAX_HOLD contested cycles
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r032_gnt0_held", 32'(gnt0), 32'd1);
    end
    step();
    chk("r032_dead_gnt0", 32'(gnt0), 32'd0);
    chk("r032_dead_gnt1", 32'(gnt1), 32'd0);
    step();
    chk("r032_gnt1", 32'(gnt1), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("r032_back_gnt0", 32'(gnt0), 32'd1);

    // Ungranted plot is ignored
    plot1 = 1; x1 = 8'd159; y1 = 7'd119; c1 = 3'd7;
    step();
    chk("r033_draw", 32'(draw_enable), 32'd0);
    chk("r033_X", 32'(X), 32'd0);
    chk("r033_Y", 32'(Y), 32'd0);

    // Release and immediate re-request is regranted straight after the dead cycle
    plot1 = 0; req1 = 0;
    step();
    req0 = 0;
    step();
    chk("r035_dead_busy", 32'(busy), 32'd1);
    chk("r035_dead_gnt0", 32'(gnt0), 32'd0);
    req0 = 1;
    step();
    chk("r035_regrant", 32'(gnt0), 32'd1);

    // Random bursty traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) req0 = ~req0;
      if ($urandom_range(0, 5) == 0) req1 = ~req1;
      plot0 = 1'($urandom_range(0, 1));
      plot1 = 1'($urandom_range(0, 1));
      x0 = X_W'($urandom_range(0, 159));
      y0 = Y_W'($urandom_range(0, 119));
      c0 = C_W'($urandom);
      x1 = X_W'($urandom_range(0, 159));
      y1 = Y_W'($urandom_range(0, 119));
      c1 = C_W'($urandom);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 SHALL have parameter X_W, default 8, pixel X width (160 columns).
REQ-002 SHALL have parameter Y_W, default 7, pixel Y width (120 rows).
REQ-003 SHALL have parameter C_W, default 3, colour width.
REQ-004 SHALL have parameter MAX_HOLD, default 255, max consecutive grant cycles while the other requester waits; legal range 1..255.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clock  in  1  system clock, 50 MHz.
REQ-007 reset  in  1  async active-high reset.
REQ-008 req0  in  1  requester 0 (3D frame renderer) wants the frame-buffer write port.
REQ-009 plot0  in  1  requester 0 pixel write strobe.
REQ-010 x0 / y0 / c0  in  X_W / Y_W / C_W  requester 0 pixel position and colour.
REQ-011 req1, plot1, x1, y1, c1  in  1, 1, X_W, Y_W, C_W  same fields for requester 1 (HUD/minimap overlay).
REQ-012 gnt0 / gnt1  out  1 / 1  port granted to requester 0 / 1.
REQ-013 X / Y / color  out  X_W / Y_W / C_W  registered pixel to frame buffer.
REQ-014 draw_enable  out  1  registered frame-buffer write enable.
REQ-015 busy  out  1  high in any state other than S_IDLE.

Function
REQ-016 SHALL implement states S_IDLE, S_GRANT0, S_GRANT1, S_SWITCH; state SHALL be registered, outputs gnt0/gnt1 decoded from state (gnt0 only in S_GRANT0, gnt1 only in S_GRANT1; never both).
REQ-017 S_IDLE: only req0 -> S_GRANT0; only req1 -> S_GRANT1; both -> grant to the requester NOT recorded in last_grant (round robin); neither -> stay.
REQ-018 last_grant SHALL update on each entry to S_GRANT0 (0) or S_GRANT1 (1); reset value 1, so first simultaneous request goes to requester 0.
REQ-019 S_GRANTn with reqn low -> S_SWITCH (release; takes effect next cycle).
REQ-020 hold counter (8 bit) SHALL clear on entry to S_GRANTn, increment each S_GRANTn cycle while the other req is high, saturate at 255.
REQ-021 S_GRANTn with other req high and hold counter == MAX_HOLD-1 SHALL go to S_SWITCH (forced release) even if reqn still high.
REQ-022 S_SWITCH SHALL last exactly one cycle, assert no grant, then go to S_GRANT of the other requester if its req is high, else back to the same requester if its req is high, else S_IDLE.
REQ-023 in cycle where gntn and plotn both high, next cycle SHALL drive draw_enable=1 and X/Y/color = xn/yn/cn (latency 1).
REQ-024 plotn while gntn low SHALL be ignored (no write, no error); draw_enable=0 otherwise.
REQ-025 X/Y/color SHALL hold last written value when draw_enable=0.
REQ-026 no pixel SHALL be lost or duplicated across a grant change: the write registered in the last S_GRANTn cycle SHALL appear on the cycle of S_SWITCH.
REQ-027 requesters SHALL be treated as bursty: a requester keeps req high for its whole clear/slice sequence and only plots while granted.

Reset
REQ-028 reset high SHALL immediately force S_IDLE, gnt0=gnt1=0, draw_enable=0, X=0, Y=0, color=0, busy=0, hold counter=0, last_grant=1, independent of clock.
REQ-029 reset asserted mid-burst SHALL drop the pending write; after release the first grant follows REQ-017 from S_IDLE.

Verification
REQ-030 req0=1 only, plot0=1, x0=5, y0=10, c0=3'b101 -> gnt0 next cycle; cycle after plot with gnt0: draw_enable=1, X=5, Y=10, color=5.
REQ-031 req0 and req1 rise same cycle after reset -> gnt0 first; req0 drops -> one S_SWITCH cycle with no grant, then gnt1.
REQ-032 MAX_HOLD=4, req0 held high, req1 high from grant start -> gnt0 exactly 4 cycles, 1 dead cycle, then gnt1.
REQ-033 plot1=1, x1=159, y1=119 while gnt0 -> draw_enable stays 0, X/Y unchanged.
REQ-034 reset pulsed in S_GRANT1 between clock edges -> gnt1 and draw_enable fall without a clock edge; all outputs 0.
REQ-035 single requester releases and re-requests during S_SWITCH -> regranted immediately after S_SWITCH, no S_IDLE cycle.
